// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Brief    : Parametrised VGA timing and test-pattern generator (solid, bars,
//            stripes, checker). Define VGA_BORDER_EN for a white frame border.
// Revision : 1.0 - initial release
// ============================================================================

module vga_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int COLOR_W    = 4,
    parameter int NUM_BARS   = 8,
    parameter int LINE_H     = 16,
    parameter int CHECK_LOG2 = 5,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HCW       = $clog2(H_TOTAL),
    localparam int VCW       = $clog2(V_TOTAL)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 PIX_EN,
    input  logic [1:0]           MODE,
    input  logic [3*COLOR_W-1:0] RGB,
    output logic                 VGA_HSYNC,
    output logic                 VGA_VSYNC,
    output logic [COLOR_W-1:0]   VGA_RED,
    output logic [COLOR_W-1:0]   VGA_GREEN,
    output logic [COLOR_W-1:0]   VGA_BLUE,
    output logic                 DE,
    output logic [HCW-1:0]       H_CNT,
    output logic [VCW-1:0]       V_CNT,
    output logic                 FRAME_START
);

    localparam int c_bar_w  = H_ACTIVE / NUM_BARS;
    localparam int c_bar_bw = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int c_px_bw  = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;
    localparam int c_hs_start = H_ACTIVE + H_FP;
    localparam int c_hs_end   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int c_vs_start = V_ACTIVE + V_FP;
    localparam int c_vs_end   = V_ACTIVE + V_FP + V_SYNC - 1;

    localparam logic [HCW-1:0]      c_h_last   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0]      c_v_last   = VCW'(V_TOTAL - 1);
    localparam logic [c_bar_bw-1:0] c_bar_last = c_bar_bw'(NUM_BARS - 1);
    localparam logic [c_px_bw-1:0]  c_px_last  = c_px_bw'(c_bar_w - 1);
    localparam logic                c_hs_idle  = (HSYNC_POL == 0) ? 1'b1 : 1'b0;
    localparam logic                c_vs_idle  = (VSYNC_POL == 0) ? 1'b1 : 1'b0;
`ifdef VGA_BORDER_EN
    localparam logic [HCW-1:0]      c_h_edge   = HCW'(H_ACTIVE - 1);
    localparam logic [VCW-1:0]      c_v_edge   = VCW'(V_ACTIVE - 1);
`endif

    logic [HCW-1:0]         r_h_cnt_q,   w_h_cnt_d;
    logic [VCW-1:0]         r_v_cnt_q,   w_v_cnt_d;
    logic                   r_hsync_q,   w_hsync_d;
    logic                   r_vsync_q,   w_vsync_d;
    logic                   r_de_q,      w_de_d;
    logic                   r_fs_q,      w_fs_d;
    logic [3*COLOR_W-1:0]   r_pix_q,     w_pix_d;
    logic [1:0]             r_mode_q,    w_mode_d;
    logic [3*COLOR_W-1:0]   r_rgb_q,     w_rgb_d;
    logic [c_bar_bw-1:0]    r_bar_q,     w_bar_d;
    logic [c_px_bw-1:0]     r_px_q,      w_px_d;

    logic                   w_h_wrap;
    logic [HCW-1:0]         w_h_nxt;
    logic [VCW-1:0]         w_v_nxt;
    logic                   w_at_origin;
    logic [1:0]             w_mode_eff;
    logic [3*COLOR_W-1:0]   w_rgb_eff;
    logic [c_bar_bw-1:0]    w_bar_nxt;
    logic [c_px_bw-1:0]     w_px_nxt;
    logic [2:0]             w_bar_idx;
    logic                   w_de_nxt;
    logic [3*COLOR_W-1:0]   w_pix;

    always_comb begin
        w_h_wrap = (r_h_cnt_q == c_h_last);
        w_h_nxt  = w_h_wrap ? '0 : r_h_cnt_q + 1'b1;
        if (!w_h_wrap)
            w_v_nxt = r_v_cnt_q;
        else if (r_v_cnt_q == c_v_last)
            w_v_nxt = '0;
        else
            w_v_nxt = r_v_cnt_q + 1'b1;

        // Shadows are taken on the tick entering (0,0) and already apply to that pixel
        w_at_origin = (w_h_nxt == '0) && (w_v_nxt == '0);
        w_mode_eff  = w_at_origin ? MODE : r_mode_q;
        w_rgb_eff   = w_at_origin ? RGB  : r_rgb_q;

        // Running bar index; the last bar absorbs the remainder of the line
        w_bar_nxt = r_bar_q;
        w_px_nxt  = r_px_q;
        if (w_h_nxt == '0) begin
            w_bar_nxt = '0;
            w_px_nxt  = '0;
        end else if (r_bar_q != c_bar_last) begin
            if (r_px_q == c_px_last) begin
                w_bar_nxt = r_bar_q + 1'b1;
                w_px_nxt  = '0;
            end else begin
                w_px_nxt  = r_px_q + 1'b1;
            end
        end
        w_bar_idx = 3'(32'(NUM_BARS - 1) - 32'(w_bar_nxt));

        w_de_nxt = (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);

        w_pix = w_rgb_eff;
        case (w_mode_eff)
            2'd1: w_pix = {{COLOR_W{w_bar_idx[2]}}, {COLOR_W{w_bar_idx[1]}},
                           {COLOR_W{w_bar_idx[0]}}};
            2'd2: if (((32'(w_v_nxt) / LINE_H) % 2) != 0) w_pix = '0;
            2'd3: if (w_h_nxt[CHECK_LOG2] ^ w_v_nxt[CHECK_LOG2]) w_pix = '0;
            default: ;
        endcase
`ifdef VGA_BORDER_EN
        if ((w_h_nxt == '0) || (w_h_nxt == c_h_edge) ||
            (w_v_nxt == '0) || (w_v_nxt == c_v_edge))
            w_pix = '1;
`endif
        if (!w_de_nxt)
            w_pix = '0;

        w_h_cnt_d = r_h_cnt_q;
        w_v_cnt_d = r_v_cnt_q;
        w_hsync_d = r_hsync_q;
        w_vsync_d = r_vsync_q;
        w_de_d    = r_de_q;
        w_fs_d    = 1'b0;
        w_pix_d   = r_pix_q;
        w_mode_d  = r_mode_q;
        w_rgb_d   = r_rgb_q;
        w_bar_d   = r_bar_q;
        w_px_d    = r_px_q;
        if (PIX_EN) begin
            w_h_cnt_d = w_h_nxt;
            w_v_cnt_d = w_v_nxt;
            w_hsync_d = ((32'(w_h_nxt) >= c_hs_start) && (32'(w_h_nxt) <= c_hs_end))
                        ? ~c_hs_idle : c_hs_idle;
            w_vsync_d = ((32'(w_v_nxt) >= c_vs_start) && (32'(w_v_nxt) <= c_vs_end))
                        ? ~c_vs_idle : c_vs_idle;
            w_de_d    = w_de_nxt;
            w_fs_d    = w_at_origin;
            w_pix_d   = w_pix;
            w_mode_d  = w_mode_eff;
            w_rgb_d   = w_rgb_eff;
            w_bar_d   = w_bar_nxt;
            w_px_d    = w_px_nxt;
        end
    end

    // Reset parks the position on the last pixel so the first tick lands on (0,0)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_h_cnt_q <= c_h_last;
            r_v_cnt_q <= c_v_last;
            r_hsync_q <= c_hs_idle;
            r_vsync_q <= c_vs_idle;
            r_de_q    <= 1'b0;
            r_fs_q    <= 1'b0;
            r_pix_q   <= '0;
            r_mode_q  <= '0;
            r_rgb_q   <= '0;
            r_bar_q   <= c_bar_last;
            r_px_q    <= '0;
        end else begin
            r_h_cnt_q <= w_h_cnt_d;
            r_v_cnt_q <= w_v_cnt_d;
            r_hsync_q <= w_hsync_d;
            r_vsync_q <= w_vsync_d;
            r_de_q    <= w_de_d;
            r_fs_q    <= w_fs_d;
            r_pix_q   <= w_pix_d;
            r_mode_q  <= w_mode_d;
            r_rgb_q   <= w_rgb_d;
            r_bar_q   <= w_bar_d;
            r_px_q    <= w_px_d;
        end
    end

    assign VGA_HSYNC   = r_hsync_q;
    assign VGA_VSYNC   = r_vsync_q;
    assign VGA_RED     = r_pix_q[3*COLOR_W-1:2*COLOR_W];
    assign VGA_GREEN   = r_pix_q[2*COLOR_W-1:COLOR_W];
    assign VGA_BLUE    = r_pix_q[COLOR_W-1:0];
    assign DE          = r_de_q;
    assign H_CNT       = r_h_cnt_q;
    assign V_CNT       = r_v_cnt_q;
    assign FRAME_START = r_fs_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_gen
// Brief    : Scoreboard bench for vga_pattern_gen on a reduced raster.
// Revision : 1.0 - initial release
// ============================================================================

module tb_vga_pattern_gen;

    localparam int HA = 68, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 24, VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int CW = 4, NB = 8, LH = 4, CL = 3;
    localparam int HCW = $clog2(HT), VCW = $clog2(VT);
    localparam int FRAME = HT * VT;
    localparam int BW = HA / NB;
`ifdef VGA_BORDER_EN
    localparam logic [11:0] EXP_ORIGIN = 12'hFFF;
    localparam logic [11:0] EXP_EDGE   = 12'hFFF;
`else
    localparam logic [11:0] EXP_ORIGIN = 12'hF0F;
    localparam logic [11:0] EXP_EDGE   = 12'h000;
`endif

    typedef struct packed {
        logic           hs;
        logic           vs;
        logic           de;
        logic           fs;
        logic [HCW-1:0] h;
        logic [VCW-1:0] v;
        logic [CW-1:0]  r;
        logic [CW-1:0]  g;
        logic [CW-1:0]  b;
    } out_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pix_en = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [3*CW-1:0]  rgb = '0;
    logic             vga_hsync, vga_vsync, de, frame_start;
    logic [CW-1:0]    red, green, blue;
    logic [HCW-1:0]   h_cnt;
    logic [VCW-1:0]   v_cnt;
    out_t             act;

    out_t             sb[$];
    int               n_cmp = 0;
    int               n_err = 0;

    int               m_h, m_v;
    logic [1:0]       m_mode;
    logic [3*CW-1:0]  m_rgb;
    out_t             m_last;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HSYNC_POL(0), .VSYNC_POL(0), .COLOR_W(CW), .NUM_BARS(NB),
        .LINE_H(LH), .CHECK_LOG2(CL)
    ) dut (
        .CLK(clk), .RST(rst), .PIX_EN(pix_en), .MODE(mode), .RGB(rgb),
        .VGA_HSYNC(vga_hsync), .VGA_VSYNC(vga_vsync),
        .VGA_RED(red), .VGA_GREEN(green), .VGA_BLUE(blue),
        .DE(de), .H_CNT(h_cnt), .V_CNT(v_cnt), .FRAME_START(frame_start)
    );

    assign act = {vga_hsync, vga_vsync, de, frame_start, h_cnt, v_cnt, red, green, blue};

    always #5 clk = ~clk;

    function automatic out_t reset_vec();
        out_t o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        o.h  = HCW'(HT - 1);
        o.v  = VCW'(VT - 1);
        return o;
    endfunction

    function automatic void model_reset();
        m_h    = HT - 1;
        m_v    = VT - 1;
        m_mode = '0;
        m_rgb  = '0;
        m_last = reset_vec();
    endfunction

    function automatic out_t model_step(input logic pe, input logic [1:0] md,
                                        input logic [3*CW-1:0] c);
        out_t          o;
        int            bar;
        logic [2:0]    idx;
        logic [CW-1:0] r, g, b;
        if (!pe) begin
            m_last.fs = 1'b0;
            return m_last;
        end
        m_h = (m_h + 1) % HT;
        if (m_h == 0) m_v = (m_v + 1) % VT;
        o    = '0;
        o.h  = HCW'(m_h);
        o.v  = VCW'(m_v);
        o.fs = (m_h == 0) && (m_v == 0);
        if (o.fs) begin
            m_mode = md;
            m_rgb  = c;
        end
        o.de = (m_h < HA) && (m_v < VA);
        o.hs = !((m_h >= HA + HFP) && (m_h < HA + HFP + HSY));
        o.vs = !((m_v >= VA + VFP) && (m_v < VA + VFP + VSY));
        {r, g, b} = m_rgb;
        case (m_mode)
            2'd1: begin
                bar = m_h / BW;
                if (bar > NB - 1) bar = NB - 1;
                idx = 3'((NB - 1 - bar) % 8);
                r = {CW{idx[2]}};
                g = {CW{idx[1]}};
                b = {CW{idx[0]}};
            end
            2'd2: if (((m_v / LH) % 2) != 0) {r, g, b} = '0;
            2'd3: if ((((m_h >> CL) ^ (m_v >> CL)) & 1) != 0) {r, g, b} = '0;
            default: ;
        endcase
`ifdef VGA_BORDER_EN
        if (m_h == 0 || m_h == HA - 1 || m_v == 0 || m_v == VA - 1) {r, g, b} = '1;
`endif
        if (o.de) begin
            o.r = r;
            o.g = g;
            o.b = b;
        end
        m_last = o;
        return o;
    endfunction

    task automatic drive_tick(input logic pe, input logic [1:0] md, input logic [3*CW-1:0] c);
        @(negedge clk);
        pix_en = pe;
        mode   = md;
        rgb    = c;
        sb.push_back(model_step(pe, md, c));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t exp;
        #1 rst = 1'b1;
        pix_en = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (act !== reset_vec()) begin
            n_err++;
            $display("FAIL reset_hold got %h want %h", act, reset_vec());
        end
        @(negedge clk);
        pix_en = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (act !== reset_vec()) begin
            n_err++;
            $display("FAIL reset_release got %h want %h", act, reset_vec());
        end
        drive_tick(1'b1, 2'd0, 12'h000);
        exp = sb.pop_front();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL first_tick got %h want %h", act, exp);
        end
        n_cmp++;
        if (!(act.fs === 1'b1 && act.h === '0 && act.v === '0 && act.de === 1'b1)) begin
            n_err++;
            $display("FAIL first_origin got fs=%b h=%0d v=%0d de=%b want fs=1 h=0 v=0 de=1",
                     act.fs, act.h, act.v, act.de);
        end
    endtask

    task automatic test_timing();
        out_t exp;
        int hs_low = 0, vs_low = 0, de_cnt = 0, fs_cnt = 0;
        int fs_last = -1, hs_first = -1, vs_first = -1;
        for (int t = 1; t <= FRAME; t++) begin
            drive_tick(1'b1, 2'd0, 12'h000);
            exp = sb.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL timing t=%0d got %h want %h", t, act, exp);
            end
            if (act.hs === 1'b0) begin
                hs_low++;
                if (act.v == 0 && hs_first < 0) hs_first = int'(act.h);
            end
            if (act.vs === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(act.v);
            end
            if (act.de === 1'b1) de_cnt++;
            if (act.fs === 1'b1) begin
                fs_cnt++;
                fs_last = t;
            end
        end
        n_cmp++;
        if (hs_low != VT * HSY) begin n_err++; $display("FAIL hs_low_count got %0d want %0d", hs_low, VT * HSY); end
        n_cmp++;
        if (hs_first != HA + HFP) begin n_err++; $display("FAIL hs_start got %0d want %0d", hs_first, HA + HFP); end
        n_cmp++;
        if (vs_low != VSY * HT) begin n_err++; $display("FAIL vs_low_count got %0d want %0d", vs_low, VSY * HT); end
        n_cmp++;
        if (vs_first != VA + VFP) begin n_err++; $display("FAIL vs_start got %0d want %0d", vs_first, VA + VFP); end
        n_cmp++;
        if (de_cnt != HA * VA) begin n_err++; $display("FAIL de_count got %0d want %0d", de_cnt, HA * VA); end
        n_cmp++;
        if (fs_cnt != 1 || fs_last != FRAME) begin
            n_err++;
            $display("FAIL fs_period got cnt=%0d at=%0d want cnt=1 at=%0d", fs_cnt, fs_last, FRAME);
        end
    endtask

    task automatic test_shadow();
        out_t exp;
        int  pre_bad = 0;
        bit  seen = 0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            drive_tick(1'b1, 2'd0, (t < 300) ? 12'h000 : 12'hF0F);
            exp = sb.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL shadow t=%0d got %h want %h", t, act, exp);
            end
            if (!seen && act.fs === 1'b1) begin
                seen = 1;
                n_cmp++;
                if ({act.r, act.g, act.b} !== EXP_ORIGIN) begin
                    n_err++;
                    $display("FAIL shadow_origin got %h want %h", {act.r, act.g, act.b}, EXP_ORIGIN);
                end
            end
            if (!seen && {act.r, act.g, act.b} === 12'hF0F) pre_bad++;
            if (seen && act.v == 1 && act.h == 5) begin
                n_cmp++;
                if ({act.r, act.g, act.b} !== 12'hF0F) begin
                    n_err++;
                    $display("FAIL shadow_active got %h want f0f", {act.r, act.g, act.b});
                end
            end
            if (seen && act.v == 1 && act.h == HA + 2) begin
                n_cmp++;
                if ({act.r, act.g, act.b} !== 12'h000) begin
                    n_err++;
                    $display("FAIL shadow_blank got %h want 000", {act.r, act.g, act.b});
                end
            end
            if (seen && act.v == 2) break;
        end
        n_cmp++;
        if (!seen || pre_bad != 0) begin
            n_err++;
            $display("FAIL shadow_tear got seen=%0d early=%0d want seen=1 early=0", seen, pre_bad);
        end
    endtask

    task automatic test_bars();
        out_t exp;
        bit   seen = 0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            drive_tick(1'b1, 2'd1, 12'h123);
            exp = sb.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL bars t=%0d got %h want %h", t, act, exp);
            end
            if (act.fs === 1'b1) seen = 1;
            if (seen && act.v == 3) begin
                if (act.h == 0 || act.h == BW || act.h == 7 * BW - 1 || act.h == 7 * BW
                    || act.h == HA - 1) begin
                    logic [11:0] want;
                    if (act.h == 0)               want = 12'hFFF;
                    else if (act.h == BW)         want = 12'hFF0;
                    else if (act.h == 7 * BW - 1) want = 12'h00F;
                    else if (act.h == 7 * BW)     want = 12'h000;
                    else                          want = EXP_EDGE;
                    n_cmp++;
                    if ({act.r, act.g, act.b} !== want) begin
                        n_err++;
                        $display("FAIL bar_px h=%0d got %h want %h", act.h, {act.r, act.g, act.b}, want);
                    end
                end
            end
            if (seen && act.v == 4) break;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL bars_timeout got no frame start want one"); end
    endtask

    task automatic test_stripes();
        out_t exp;
        bit   seen = 0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            drive_tick(1'b1, 2'd2, 12'h5A3);
            exp = sb.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL stripes t=%0d got %h want %h", t, act, exp);
            end
            if (act.fs === 1'b1) seen = 1;
            if (seen && act.h == 10 && (act.v == 5 || act.v == 8)) begin
                n_cmp++;
                if ({act.r, act.g, act.b} !== ((act.v == 5) ? 12'h000 : 12'h5A3)) begin
                    n_err++;
                    $display("FAIL stripe_px v=%0d got %h want %h", act.v, {act.r, act.g, act.b},
                             (act.v == 5) ? 12'h000 : 12'h5A3);
                end
            end
            if (seen && act.v == 5 && act.h == 0) begin
                n_cmp++;
                if ({act.r, act.g, act.b} !== EXP_EDGE) begin
                    n_err++;
                    $display("FAIL edge_left got %h want %h", {act.r, act.g, act.b}, EXP_EDGE);
                end
            end
            if (seen && act.v == 9) break;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL stripes_timeout got no frame start want one"); end
    endtask

    task automatic test_checker();
        out_t exp;
        bit   seen = 0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            drive_tick(1'b1, 2'd3, 12'h3C7);
            exp = sb.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL checker t=%0d got %h want %h", t, act, exp);
            end
            if (act.fs === 1'b1) seen = 1;
            if (seen && (act.v == 1 || act.v == 9) && (act.h == 3 || act.h == 10)) begin
                logic [11:0] want;
                want = ((act.v == 1) == (act.h == 3)) ? 12'h3C7 : 12'h000;
                n_cmp++;
                if ({act.r, act.g, act.b} !== want) begin
                    n_err++;
                    $display("FAIL checker_px h=%0d v=%0d got %h want %h", act.h, act.v,
                             {act.r, act.g, act.b}, want);
                end
            end
            if (seen && act.v == 10) break;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL checker_timeout got no frame start want one"); end
    endtask

    task automatic test_pix_en();
        out_t exp;
        logic prev_hs = 1'b1, prev_fs = 1'b0;
        int   last_fall = -1, period = -1, fs_cnt = 0, fs_wide = 0;
        for (int c = 0; c < 4 * (FRAME + 2); c++) begin
            drive_tick((c % 4) == 0, 2'd3, 12'h3C7);
            exp = sb.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL pixen c=%0d got %h want %h", c, act, exp);
            end
            if (prev_hs === 1'b1 && act.hs === 1'b0) begin
                if (last_fall >= 0) period = c - last_fall;
                last_fall = c;
            end
            if (act.fs === 1'b1) begin
                fs_cnt++;
                if (prev_fs === 1'b1) fs_wide++;
            end
            prev_hs = act.hs;
            prev_fs = act.fs;
        end
        n_cmp++;
        if (period != 4 * HT) begin n_err++; $display("FAIL hs_period_clk got %0d want %0d", period, 4 * HT); end
        n_cmp++;
        if (fs_cnt != 1 || fs_wide != 0) begin
            n_err++;
            $display("FAIL fs_width got cnt=%0d wide=%0d want cnt=1 wide=0", fs_cnt, fs_wide);
        end
    endtask

    task automatic test_mid_reset();
        out_t exp;
        bit   hit = 0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            drive_tick(1'b1, 2'd0, 12'h0F0);
            exp = sb.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL pre_reset t=%0d got %h want %h", t, act, exp);
            end
            if (act.h == 30 && act.v == 10) begin
                hit = 1;
                break;
            end
        end
        n_cmp++;
        if (!hit) begin n_err++; $display("FAIL mid_reset_timeout got no (30,10) want it"); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (act !== reset_vec()) begin
            n_err++;
            $display("FAIL reset_async got %h want %h", act, reset_vec());
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (act !== reset_vec()) begin
            n_err++;
            $display("FAIL reset_mid_hold got %h want %h", act, reset_vec());
        end
        @(negedge clk);
        pix_en = 1'b0;
        rst    = 1'b0;
        for (int t = 0; t < 100; t++) begin
            drive_tick(1'b1, 2'd0, 12'h0F0);
            exp = sb.pop_front();
            n_cmp++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL restart t=%0d got %h want %h", t, act, exp);
            end
            if (t == 0) begin
                n_cmp++;
                if (!(act.fs === 1'b1 && act.h === '0 && act.v === '0)) begin
                    n_err++;
                    $display("FAIL restart_origin got fs=%b h=%0d v=%0d want fs=1 h=0 v=0",
                             act.fs, act.h, act.v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_shadow();
        test_bars();
        test_stripes();
        test_checker();
        test_pix_en();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
